// File: rtl/dual_rail_zero_counter.sv
// Synchronised dual-rail token counter: tallies zero-valued lanes modulo MOD over a
// four-phase return-to-zero handshake and reports a dual-rail residue flag plus the count.
module dual_rail_zero_counter #(
   parameter int WIDTH       = 1,
   parameter int MOD         = 2,
   parameter int SYNC_STAGES = 2,
   localparam int CW         = ($clog2(MOD) > 1) ? $clog2(MOD) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bit1,
   input  logic [WIDTH-1:0] bit0,
   input  logic             clear,
   output logic             parity0,
   output logic             parity1,
   output logic [CW-1:0]    zero_count,
   output logic             error
);

   localparam int SW = $clog2(MOD + WIDTH);
   localparam int ZW = $clog2(WIDTH + 1);
   localparam logic [SW-1:0] MOD_W = SW'(MOD);

   typedef enum logic [2:0] {
      NULL_WAIT,
      EVAL,
      OUT_SET,
      OUT_CLR,
      ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             p0_q, p0_d;
   logic             p1_q, p1_d;
   logic             error_q, error_d;

   logic [WIDTH-1:0] sync1_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync0_q [SYNC_STAGES];
   logic [WIDTH-1:0] s1, s0;
   logic             all_valid, any_illegal, all_null;
   logic [ZW-1:0]    z;
   logic [SW-1:0]    sum;
   logic [CW-1:0]    sum_mod;

   // NOTE: the synchroniser array is tiny, so every stage is reset; a reset-less
   // RAM would keep stale rails across rst_n and could fake a codeword.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync1_q[i] <= '0;
            sync0_q[i] <= '0;
         end
      end else begin
         sync1_q[0] <= bit1;
         sync0_q[0] <= bit0;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync1_q[i] <= sync1_q[i-1];
            sync0_q[i] <= sync0_q[i-1];
         end
      end
   end

   assign s1          = sync1_q[SYNC_STAGES-1];
   assign s0          = sync0_q[SYNC_STAGES-1];
   assign all_valid   = &(s1 ^ s0);
   assign any_illegal = |(s1 & s0);
   assign all_null    = ~|(s1 | s0);

   always_comb begin
      z = '0;
      for (int i = 0; i < WIDTH; i++) begin
         z = z + ZW'(s0[i]);
      end
      sum     = SW'(count_q) + SW'(z);
      sum_mod = CW'(sum % MOD_W);
   end

   // NOTE: every next-state variable gets its hold value first, so no path through
   // the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      error_d = error_q;
      case (state_q)
         NULL_WAIT: begin
            if (clear) count_d = '0;
            if (any_illegal)    state_d = ERROR;
            else if (all_valid) state_d = EVAL;
         end
         EVAL: begin
            count_d = sum_mod;
            p0_d    = (sum_mod == '0);
            p1_d    = (sum_mod != '0);
            state_d = OUT_SET;
         end
         OUT_SET: begin
            if (any_illegal)   state_d = ERROR;
            else if (all_null) state_d = OUT_CLR;
         end
         OUT_CLR: state_d = NULL_WAIT;
         ERROR:   state_d = ERROR;
         default: state_d = NULL_WAIT;
      endcase
      // Result rails may only be high while the token is being presented.
      if (state_d != OUT_SET) begin
         p0_d = 1'b0;
         p1_d = 1'b0;
      end
      if (state_d == ERROR) error_d = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together
   // from values sampled at the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NULL_WAIT;
         count_q <= '0;
         p0_q    <= 1'b0;
         p1_q    <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         error_q <= error_d;
      end
   end

   assign parity0    = p0_q;
   assign parity1    = p1_q;
   assign zero_count = count_q;
   assign error      = error_q;

endmodule

// File: tb/tb_dual_rail_zero_counter.sv
// Directed bench: one default instance (WIDTH=1, MOD=2) and one WIDTH=4, MOD=3 instance,
// driven on the falling edge and sampled on the falling edge.
module tb_dual_rail_zero_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       bit1_a = 1'b0, bit0_a = 1'b0, clear_a = 1'b0;
   logic       parity0_a, parity1_a, error_a;
   logic [0:0] zero_count_a;

   logic [3:0] bit1_b = '0, bit0_b = '0;
   logic       clear_b = 1'b0;
   logic       parity0_b, parity1_b, error_b;
   logic [1:0] zero_count_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_rail_zero_counter dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit1       (bit1_a),
      .bit0       (bit0_a),
      .clear      (clear_a),
      .parity0    (parity0_a),
      .parity1    (parity1_a),
      .zero_count (zero_count_a),
      .error      (error_a)
   );

   dual_rail_zero_counter #(.WIDTH(4), .MOD(3), .SYNC_STAGES(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit1       (bit1_b),
      .bit0       (bit0_b),
      .clear      (clear_b),
      .parity0    (parity0_b),
      .parity1    (parity1_b),
      .zero_count (zero_count_b),
      .error      (error_b)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic token_a(input logic v);
      @(negedge clk);
      bit1_a = v;
      bit0_a = ~v;
      cycles(4);
   endtask

   task automatic null_a();
      @(negedge clk);
      bit1_a = 1'b0;
      bit0_a = 1'b0;
      cycles(4);
      check("a_null_rails", {parity1_a, parity0_a}, 0);
   endtask

   task automatic token_b(input logic [3:0] v);
      @(negedge clk);
      bit1_b = v;
      bit0_b = ~v;
      cycles(4);
   endtask

   task automatic null_b();
      @(negedge clk);
      bit1_b = '0;
      bit0_b = '0;
      cycles(4);
      check("b_null_rails", {parity1_b, parity0_b}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cycles(2);
      check("rst_a_rails", {parity1_a, parity0_a}, 0);
      check("rst_a_count", zero_count_a, 0);
      check("rst_a_error", error_a, 0);
      check("rst_b_count", zero_count_b, 0);
      rst_n = 1'b1;
      cycles(2);

      // Defaults: exact rise latency, then bit0, bit1, bit0 tokens.
      @(negedge clk);
      bit1_a = 1'b0;
      bit0_a = 1'b1;
      cycles(3);
      check("a_lat_early", parity1_a, 0);
      cycles(1);
      check("a_lat_rise", parity1_a, 1);
      check("a_t1_count", zero_count_a, 1);
      check("a_t1_p0", parity0_a, 0);
      null_a();
      token_a(1'b1);
      check("a_t2_p1", parity1_a, 1);
      check("a_t2_count", zero_count_a, 1);
      null_a();
      token_a(1'b0);
      check("a_t3_p0", parity0_a, 1);
      check("a_t3_p1", parity1_a, 0);
      check("a_t3_count", zero_count_a, 0);
      null_a();

      // WIDTH=4, MOD=3 token sequence.
      token_b(4'b0000);
      check("b_t1_count", zero_count_b, 1);
      check("b_t1_p1", parity1_b, 1);
      null_b();
      token_b(4'b0010);
      check("b_t2_count", zero_count_b, 1);
      check("b_t2_p1", parity1_b, 1);
      null_b();
      token_b(4'b0011);
      check("b_t3_count", zero_count_b, 0);
      check("b_t3_p0", {parity1_b, parity0_b}, 1);
      null_b();

      // Partial codeword: lanes 0-2 only, then lane 3 completes it.
      @(negedge clk);
      bit1_b = 4'b0110;
      bit0_b = 4'b0001;
      cycles(10);
      check("b_part_rails", {parity1_b, parity0_b}, 0);
      check("b_part_count", zero_count_b, 0);
      bit1_b[3] = 1'b1;
      cycles(4);
      check("b_full_p1", parity1_b, 1);
      check("b_full_count", zero_count_b, 1);
      bit1_b[2:0] = 3'b000;
      bit0_b[2:0] = 3'b000;
      cycles(10);
      check("b_hold_p1", parity1_b, 1);
      null_b();
      check("b_after_count", zero_count_b, 1);

      // Illegal code in NULL_WAIT.
      @(negedge clk);
      bit1_a = 1'b1;
      bit0_a = 1'b1;
      cycles(2);
      check("a_err_early", error_a, 0);
      cycles(1);
      check("a_err_set", error_a, 1);
      check("a_err_rails", {parity1_a, parity0_a}, 0);
      bit1_a = 1'b0;
      bit0_a = 1'b0;
      clear_a = 1'b1;
      cycles(6);
      clear_a = 1'b0;
      check("a_err_sticky", error_a, 1);
      token_a(1'b0);
      check("a_err_frozen", zero_count_a, 0);
      check("a_err_norail", {parity1_a, parity0_a}, 0);
      bit0_a = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("a_err_cleared", error_a, 0);
      @(negedge clk) rst_n = 1'b1;
      cycles(2);

      // Asynchronous reset while in OUT_SET.
      token_a(1'b0);
      check("a_pre_rst_p1", parity1_a, 1);
      check("a_pre_rst_count", zero_count_a, 1);
      #2 rst_n = 1'b0;
      #1;
      check("a_mid_rst_rails", {parity1_a, parity0_a}, 0);
      check("a_mid_rst_count", zero_count_a, 0);
      bit0_a = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cycles(2);
      token_a(1'b1);
      check("a_post_rst_p0", {parity1_a, parity0_a}, 1);
      check("a_post_rst_count", zero_count_a, 0);
      null_a();

      // Clear together with a complete token, then clear during OUT_SET.
      token_a(1'b0);
      null_a();
      check("a_pre_clr_count", zero_count_a, 1);
      @(negedge clk);
      clear_a = 1'b1;
      bit0_a  = 1'b1;
      cycles(4);
      clear_a = 1'b0;
      check("a_clr_count", zero_count_a, 1);
      check("a_clr_p1", {parity1_a, parity0_a}, 2);
      clear_a = 1'b1;
      cycles(3);
      check("a_clr_out_count", zero_count_a, 1);
      check("a_clr_out_p1", parity1_a, 1);
      clear_a = 1'b0;
      null_a();
      check("a_clr_end_count", zero_count_a, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
